// File: rtl/imsic_msi_arbiter_if.sv
// Requester-side bundle of the IMSIC MSI arbiter.
// Requester r owns req_info[r*MSI_INFO_WIDTH +: MSI_INFO_WIDTH].
interface imsic_msi_arbiter_if #(
    parameter int NR_REQ         = 4,
    parameter int MSI_INFO_WIDTH = 17
);
    logic [NR_REQ-1:0]                req_vld;
    logic [NR_REQ-1:0]                req_rdy;
    logic [NR_REQ*MSI_INFO_WIDTH-1:0] req_info;

    modport master (
        output req_vld,
        output req_info,
        input  req_rdy
    );

    modport slave (
        input  req_vld,
        input  req_info,
        output req_rdy
    );
endinterface

// File: rtl/imsic_msi_arbiter.sv
// Round-robin MSI arbiter and pulse pacer in front of the IMSIC CSR gate.
// Optional macro IMSIC_MSI_ARB_DROP_CHK_EN: drop and count invalid MSIs.
module imsic_msi_arbiter #(
    parameter int NR_REQ         = 4,
    parameter int MSI_INFO_WIDTH = 17,
    parameter int NR_SRC         = 32,
    parameter int NR_INTP_FILES  = 7,
    parameter int HOLD_CYC       = 4,
    parameter int GAP_CYC        = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    imsic_msi_arbiter_if.slave         req,
    output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
    output logic                       o_msi_info_vld,
    output logic                       o_busy,
    output logic [$clog2(NR_REQ)-1:0]  o_grant_id
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);
    localparam int IDW     = $clog2(NR_REQ);
    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    if (NR_REQ < 2 || NR_REQ > 16 || HOLD_CYC < 1 || GAP_CYC < 1 ||
        NR_SRC < 2 || NR_INTP_FILES < 1) begin : g_cfg_err
        $error("imsic_msi_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_e;

    state_e                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [IDW-1:0]            rr_ptr_q;
    logic [IDW-1:0]            rr_ptr_d;
    logic [IDW-1:0]            grant_q;
    logic [MSI_INFO_WIDTH-1:0] info_q;
    logic                      vld_q;
    logic                      busy_q;

    logic [2*NR_REQ-1:0]       dbl;
    logic [NR_REQ-1:0]         rot;
    logic [IDW-1:0]            ofs;
    logic [IDW:0]              sum;
    logic [IDW-1:0]            win;
    logic                      found;
    logic                      accept;
    logic                      fwd;
    logic [MSI_INFO_WIDTH-1:0] info_w;

    // Rotate so the search always starts at bit 0, then map back.
    always_comb begin
        dbl   = {req.req_vld, req.req_vld};
        rot   = NR_REQ'(dbl >> rr_ptr_q);
        found = 1'b0;
        ofs   = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                ofs   = IDW'(i);
            end
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, ofs};
        if (sum >= (IDW+1)'(NR_REQ)) begin
            sum = sum - (IDW+1)'(NR_REQ);
        end
        win      = sum[IDW-1:0];
        rr_ptr_d = (win == IDW'(NR_REQ - 1)) ? '0 : win + 1'b1;
    end

    assign accept = (state_q == IDLE) && found;

    always_comb begin
        req.req_rdy = '0;
        if (accept) begin
            req.req_rdy[win] = 1'b1;
        end
    end

    always_comb begin
        info_w = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (win == IDW'(i)) begin
                info_w = req.req_info[i*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
            end
        end
    end

`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
    localparam int SRCW = $clog2(NR_SRC);
    localparam int FW   = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1;

    logic [SRCW-1:0] src;
    logic [FW-1:0]   file;
    logic [15:0]     drop_cnt_q;

    assign src      = info_w[SRCW-1:0];
    assign file     = info_w[SRCW +: FW];
    assign fwd      = (src != '0) && (32'(src) < NR_SRC) &&
                      (32'(file) < NR_INTP_FILES);
    assign drop_cnt = drop_cnt_q;
`else
    assign fwd = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            info_q     <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        rr_ptr_q <= rr_ptr_d;
                        grant_q  <= win;
                        if (fwd) begin
                            info_q  <= info_w;
                            vld_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ASSERT;
                        end
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
                        else if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
`endif
                    end
                end
                ASSERT: begin
                    if (cnt_q == CW'(HOLD_CYC - 1)) begin
                        cnt_q   <= '0;
                        vld_q   <= 1'b0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_CYC - 1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_msi_info     = info_q;
    assign o_msi_info_vld = vld_q;
    assign o_busy         = busy_q;
    assign o_grant_id     = grant_q;
endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Bench for imsic_msi_arbiter: directed scenarios plus random traffic
// against a cycle-level model (IMSIC_MSI_ARB_DROP_CHK_EN adds drop tests).
module tb_imsic_msi_arbiter;
    localparam int NR_REQ = 4;
    localparam int W      = 17;
    localparam int NR_SRC = 32;
    localparam int NR_F   = 7;
    localparam int HOLD   = 4;
    localparam int GAP    = 4;
    localparam int PERIOD = 1 + HOLD + GAP;
    localparam int SRCW   = $clog2(NR_SRC);
    localparam int FW     = $clog2(NR_F);

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    imsic_msi_arbiter_if #(.NR_REQ(NR_REQ), .MSI_INFO_WIDTH(W)) rif ();

    logic [W-1:0] o_msi_info;
    logic         o_msi_info_vld;
    logic         o_busy;
    logic [1:0]   o_grant_id;
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
    logic [15:0]  drop_cnt;
`endif

    imsic_msi_arbiter #(
        .NR_REQ(NR_REQ), .MSI_INFO_WIDTH(W), .NR_SRC(NR_SRC),
        .NR_INTP_FILES(NR_F), .HOLD_CYC(HOLD), .GAP_CYC(GAP)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req            (rif),
        .o_msi_info     (o_msi_info),
        .o_msi_info_vld (o_msi_info_vld),
        .o_busy         (o_busy),
        .o_grant_id     (o_grant_id)
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [W-1:0] info);
        rif.req_vld[r]         = v;
        rif.req_info[r*W +: W] = info;
    endtask

    task automatic do_reset();
        tick();
        rstn         = 1'b0;
        rif.req_vld  = '0;
        rif.req_info = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    function automatic logic [W-1:0] mk_info(input int hart, input int file, input int src);
        logic [W-1:0] v;
        v = W'(src) | (W'(file) << SRCW) | (W'(hart) << (SRCW + FW));
        return v;
    endfunction

    function automatic bit msi_ok(input logic [W-1:0] info);
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
        int src;
        int file;
        src  = int'(info[SRCW-1:0]);
        file = int'(info[SRCW +: FW]);
        return (src != 0) && (src < NR_SRC) && (file < NR_F);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [W-1:0] gen_info();
        if ($urandom_range(3) == 0) begin
            return W'($urandom);
        end
        return mk_info($urandom_range(511), $urandom_range(NR_F - 1),
                       $urandom_range(NR_SRC - 1, 1));
    endfunction

    task automatic test_reset();
        rstn         = 1'b0;
        rif.req_vld  = '0;
        rif.req_info = '0;
        tick();
        checks++;
        if ({o_msi_info_vld, o_busy, o_grant_id} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl: got vld/busy/gid=%b want 0000",
                     {o_msi_info_vld, o_busy, o_grant_id});
        end
        checks++;
        if (o_msi_info !== '0) begin
            errors++;
            $display("FAIL reset_info: got %h want 0", o_msi_info);
        end
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop: got %0d want 0", drop_cnt);
        end
`endif
        rstn = 1'b1;
        tick();
        checks++;
        if ({o_msi_info_vld, o_busy} !== 2'b0 || rif.req_rdy !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got vld=%b busy=%b rdy=%b want 0 0 0000",
                     o_msi_info_vld, o_busy, rif.req_rdy);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1'b1, 17'h0_0005);
        #1;
        checks++;
        if (rif.req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL single_rdy: got %b want 0001", rif.req_rdy);
        end
        tick();
        set_req(0, 1'b0, '0);
        for (int k = 1; k <= PERIOD; k++) begin
            checks++;
            if (o_msi_info_vld !== (k <= HOLD) || o_busy !== (k < PERIOD)) begin
                errors++;
                $display("FAIL single_pulse: cyc %0d got vld=%b busy=%b want %b %b",
                         k, o_msi_info_vld, o_busy, k <= HOLD, k < PERIOD);
            end
            checks++;
            if (o_msi_info !== 17'h0_0005 || o_grant_id !== 2'd0) begin
                errors++;
                $display("FAIL single_info: cyc %0d got info=%h gid=%0d want 00005 0",
                         k, o_msi_info, o_grant_id);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        int ids[$];
        int cyc[$];
        int last;
        do_reset();
        for (int r = 0; r < NR_REQ; r++) begin
            set_req(r, 1'b1, mk_info(r, r, r + 1));
        end
        last = -1;
        for (int c = 0; c < 5 * PERIOD; c++) begin
            #1;
            if (rif.req_rdy !== 4'b0) begin
                checks++;
                if ($countones(rif.req_rdy) != 1) begin
                    errors++;
                    $display("FAIL rot_onehot: got %b want one-hot", rif.req_rdy);
                end
                for (int r = 0; r < NR_REQ; r++) begin
                    if (rif.req_rdy[r]) last = r;
                end
                ids.push_back(last);
                cyc.push_back(c);
            end
            tick();
            if (last >= 0) begin
                checks++;
                if (o_grant_id !== 2'(last) || o_msi_info !== mk_info(last, last, last + 1)) begin
                    errors++;
                    $display("FAIL rot_gid: got gid=%0d info=%h want %0d %h",
                             o_grant_id, o_msi_info, last, mk_info(last, last, last + 1));
                end
            end
        end
        checks++;
        if (ids.size() != 5) begin
            errors++;
            $display("FAIL rot_count: got %0d accepts want 5", ids.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ids[i] != i % NR_REQ || cyc[i] != i * PERIOD) begin
                    errors++;
                    $display("FAIL rot_order: accept %0d got id=%0d cyc=%0d want %0d %0d",
                             i, ids[i], cyc[i], i % NR_REQ, i * PERIOD);
                end
            end
        end
    endtask

    task automatic test_rr_skip();
        do_reset();
        set_req(1, 1'b1, mk_info(1, 1, 1));
        #1;
        tick();
        set_req(1, 1'b0, '0);
        repeat (PERIOD - 1) tick();
        set_req(0, 1'b1, mk_info(0, 0, 9));
        set_req(3, 1'b1, mk_info(3, 3, 3));
        #1;
        checks++;
        if (rif.req_rdy !== 4'b1000) begin
            errors++;
            $display("FAIL skip_first: got %b want 1000", rif.req_rdy);
        end
        tick();
        set_req(3, 1'b0, '0);
        checks++;
        if (o_grant_id !== 2'd3) begin
            errors++;
            $display("FAIL skip_gid3: got %0d want 3", o_grant_id);
        end
        repeat (PERIOD - 1) tick();
        #1;
        checks++;
        if (rif.req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL skip_second: got %b want 0001", rif.req_rdy);
        end
        tick();
        set_req(0, 1'b0, '0);
        checks++;
        if (o_grant_id !== 2'd0 || o_msi_info !== mk_info(0, 0, 9)) begin
            errors++;
            $display("FAIL skip_gid0: got gid=%0d info=%h want 0 %h",
                     o_grant_id, o_msi_info, mk_info(0, 0, 9));
        end
    endtask

    task automatic test_mid_assert();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = mk_info(5, 2, 7);
        b = mk_info(6, 4, 30);
        do_reset();
        set_req(0, 1'b1, a);
        #1;
        tick();
        set_req(0, 1'b0, '0);
        tick();
        set_req(1, 1'b1, b);
        for (int k = 2; k < PERIOD; k++) begin
            #1;
            checks++;
            if (rif.req_rdy !== 4'b0 || o_msi_info !== a) begin
                errors++;
                $display("FAIL mid_wait: cyc %0d got rdy=%b info=%h want 0000 %h",
                         k, rif.req_rdy, o_msi_info, a);
            end
            tick();
        end
        #1;
        checks++;
        if (rif.req_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL mid_grant: got %b want 0010", rif.req_rdy);
        end
        tick();
        set_req(1, 1'b0, '0);
        checks++;
        if (o_msi_info !== b || o_msi_info_vld !== 1'b1 || o_grant_id !== 2'd1) begin
            errors++;
            $display("FAIL mid_fwd: got info=%h vld=%b gid=%0d want %h 1 1",
                     o_msi_info, o_msi_info_vld, o_grant_id, b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 1'b1, mk_info(1, 1, 11));
        #1;
        tick();
        set_req(1, 1'b0, '0);
        set_req(2, 1'b1, mk_info(2, 2, 22));
        tick();
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({o_msi_info_vld, o_busy, o_grant_id} !== 4'b0 || o_msi_info !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got vld=%b busy=%b gid=%0d info=%h want zeros",
                     o_msi_info_vld, o_busy, o_grant_id, o_msi_info);
        end
        set_req(0, 1'b1, mk_info(0, 0, 4));
        #1;
        rstn = 1'b1;
        #1;
        checks++;
        if (rif.req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr: got %b want 0001", rif.req_rdy);
        end
        tick();
        set_req(0, 1'b0, '0);
        set_req(2, 1'b0, '0);
    endtask

`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
    task automatic test_drop();
        logic [W-1:0] bad [3];
        bad[0] = 17'h1_0000;
        bad[1] = 17'h0_0020;
        bad[2] = 17'h0_00E1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, bad[i]);
            #1;
            checks++;
            if (rif.req_rdy !== 4'b0001) begin
                errors++;
                $display("FAIL drop_rdy: msi %0d got %b want 0001", i, rif.req_rdy);
            end
            tick();
            checks++;
            if (o_msi_info_vld !== 1'b0 || o_busy !== 1'b0 || o_msi_info !== '0) begin
                errors++;
                $display("FAIL drop_quiet: msi %0d got vld=%b busy=%b info=%h want 0 0 0",
                         i, o_msi_info_vld, o_busy, o_msi_info);
            end
        end
        checks++;
        if (drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL drop_cnt: got %0d want 3", drop_cnt);
        end
        set_req(0, 1'b1, 17'h0_0021);
        #1;
        tick();
        set_req(0, 1'b0, '0);
        checks++;
        if (o_msi_info_vld !== 1'b1 || o_msi_info !== 17'h0_0021 || drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL drop_fwd: got vld=%b info=%h cnt=%0d want 1 00021 3",
                     o_msi_info_vld, o_msi_info, drop_cnt);
        end
    endtask
`endif

    task automatic test_random();
        bit           pend  [NR_REQ];
        logic [W-1:0] pinfo [NR_REQ];
        logic [3:0]   exp_rdy;
        logic [W-1:0] m_info;
        int           m_ptr;
        int           m_gid;
        int           m_drop;
        int           last_fwd;
        int           w;
        int           d;
        do_reset();
        m_info   = '0;
        m_ptr    = 0;
        m_gid    = 0;
        m_drop   = 0;
        last_fwd = -1000;
        for (int r = 0; r < NR_REQ; r++) begin
            pend[r]  = 1'b0;
            pinfo[r] = '0;
        end
        for (int t = 0; t < 800; t++) begin
            d = t - last_fwd;
            checks++;
            if (o_msi_info_vld !== (d >= 1 && d <= HOLD) ||
                o_busy !== (d >= 1 && d < PERIOD) ||
                o_msi_info !== m_info || o_grant_id !== 2'(m_gid)) begin
                errors++;
                $display("FAIL rand_out: t=%0d got vld=%b busy=%b info=%h gid=%0d want %b %b %h %0d",
                         t, o_msi_info_vld, o_busy, o_msi_info, o_grant_id,
                         d >= 1 && d <= HOLD, d >= 1 && d < PERIOD, m_info, m_gid);
            end
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
            checks++;
            if (drop_cnt !== 16'(m_drop)) begin
                errors++;
                $display("FAIL rand_drop: t=%0d got %0d want %0d", t, drop_cnt, m_drop);
            end
`endif
            for (int r = 0; r < NR_REQ; r++) begin
                if (!pend[r] && $urandom_range(3) == 0) begin
                    pend[r]  = 1'b1;
                    pinfo[r] = gen_info();
                end
                set_req(r, pend[r], pinfo[r]);
            end
            #1;
            w       = -1;
            exp_rdy = '0;
            if (d >= PERIOD) begin
                for (int i = 0; i < NR_REQ; i++) begin
                    if (w < 0 && pend[(m_ptr + i) % NR_REQ]) w = (m_ptr + i) % NR_REQ;
                end
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            checks++;
            if (rif.req_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL rand_rdy: t=%0d got %b want %b", t, rif.req_rdy, exp_rdy);
            end
            if (w >= 0) begin
                pend[w] = 1'b0;
                m_ptr   = (w + 1) % NR_REQ;
                m_gid   = w;
                if (msi_ok(pinfo[w])) begin
                    m_info   = pinfo[w];
                    last_fwd = t;
                end else if (m_drop < 16'hFFFF) begin
                    m_drop++;
                end
            end
            tick();
        end
    endtask

    initial begin
        rif.req_vld  = '0;
        rif.req_info = '0;
        test_reset();
        test_single();
        test_rotation();
        test_rr_skip();
        test_mid_assert();
        test_reset_mid();
`ifdef IMSIC_MSI_ARB_DROP_CHK_EN
        test_drop();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
